// File: rtl/fp16_div_iter_if.sv
// fp16_div_iter_if
// Handshake and operand bundle for the iterative fp16 divider.
//   start_59       requester -> divider : start request, sampled while idle
//   numA59         requester -> divider : dividend (fp16)
//   numB59         requester -> divider : divisor (fp16)
//   busy_59        divider -> requester : operation in progress
//   done_59        divider -> requester : one-cycle completion pulse
//   Div_result_59  divider -> requester : quotient, held until next done
interface fp16_div_iter_if;
  logic        start_59;
  logic [15:0] numA59;
  logic [15:0] numB59;
  logic        busy_59;
  logic        done_59;
  logic [15:0] Div_result_59;

  modport master (
    output start_59, numA59, numB59,
    input  busy_59, done_59, Div_result_59
  );

  modport slave (
    input  start_59, numA59, numB59,
    output busy_59, done_59, Div_result_59
  );
endinterface

// File: rtl/fp16_div_iter.sv
// fp16_div_iter
// Iterative IEEE-754 half-precision divider using restoring division, one
// quotient bit per clock. Truncating, flush-to-zero, fixed 14-edge latency.
//   clk_59    : rising-edge clock
//   reset_59  : synchronous active-high reset
//   bus       : fp16_div_iter_if.slave (start/operands in, busy/done/result out)
module fp16_div_iter (
  input  logic          clk_59,
  input  logic          reset_59,
  fp16_div_iter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state, state_next;
  logic        busy, busy_next;
  logic        done, done_next;
  logic [15:0] result, result_next;
  logic [12:0] rem, rem_next;
  logic [11:0] quot, quot_next;
  logic [3:0]  cnt, cnt_next;
  logic        sign, sign_next;
  logic [4:0]  exp_a, exp_a_next;
  logic [4:0]  exp_b, exp_b_next;
  logic [10:0] man_b, man_b_next;
  logic        special, special_next;
  logic [15:0] special_res, special_res_next;
  logic [15:0] norm_res, norm_res_next;

  // Operand classification, only meaningful on the accepting edge.
  logic        in_sign;
  logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic [12:0] trial;
  logic        trial_ok;
  logic signed [6:0] exp_q;
  logic [9:0]  mant_q;

  assign in_sign = bus.numA59[15] ^ bus.numB59[15];
  assign nan_a   = (bus.numA59[14:10] == 5'h1F) && (bus.numA59[9:0] != 10'h0);
  assign nan_b   = (bus.numB59[14:10] == 5'h1F) && (bus.numB59[9:0] != 10'h0);
  assign inf_a   = (bus.numA59[14:10] == 5'h1F) && (bus.numA59[9:0] == 10'h0);
  assign inf_b   = (bus.numB59[14:10] == 5'h1F) && (bus.numB59[9:0] == 10'h0);
  assign zero_a  = (bus.numA59[14:10] == 5'h00);
  assign zero_b  = (bus.numB59[14:10] == 5'h00);

  // rem always stays below 2*mB, so a 13-bit difference never wraps when
  // the comparison says the subtraction is allowed.
  assign trial    = rem - {2'b00, man_b};
  assign trial_ok = (rem >= {2'b00, man_b});

  // A quotient of two [1,2) significands lies in (0.5,2): either q[11] or
  // q[10] is the leading one, which selects the exponent bias adjustment.
  assign exp_q  = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b})
                  + (quot[11] ? 7'sd15 : 7'sd14);
  assign mant_q = quot[11] ? quot[10:1] : quot[9:0];

  assign bus.busy_59       = busy;
  assign bus.done_59       = done;
  assign bus.Div_result_59 = result;

  // Next-state and datapath: every register holds unless its state updates it.
  always_comb begin
    state_next       = state;
    busy_next        = busy;
    done_next        = 1'b0;
    result_next      = result;
    rem_next         = rem;
    quot_next        = quot;
    cnt_next         = cnt;
    sign_next        = sign;
    exp_a_next       = exp_a;
    exp_b_next       = exp_b;
    man_b_next       = man_b;
    special_next     = special;
    special_res_next = special_res;
    norm_res_next    = norm_res;

    case (state)
      IDLE: begin
        if (bus.start_59) begin
          busy_next    = 1'b1;
          sign_next    = in_sign;
          exp_a_next   = bus.numA59[14:10];
          exp_b_next   = bus.numB59[14:10];
          man_b_next   = {1'b1, bus.numB59[9:0]};
          rem_next     = {2'b01, bus.numA59[9:0]};
          quot_next    = 12'h000;
          cnt_next     = 4'd11;
          special_next = 1'b1;
          // Special results are fixed here; the datapath still runs so
          // latency does not depend on the operands.
          if (nan_a || nan_b || (inf_a && inf_b) || (zero_a && zero_b)) begin
            special_res_next = 16'h7E00;
          end else if (zero_a) begin
            special_res_next = 16'h0000;
          end else if (zero_b || inf_a) begin
            special_res_next = {in_sign, 5'h1F, 10'h000};
          end else if (inf_b) begin
            special_res_next = 16'h0000;
          end else begin
            special_next     = 1'b0;
            special_res_next = 16'h0000;
          end
          state_next = DIV;
        end
      end

      DIV: begin
        if (trial_ok) begin
          rem_next  = {trial[11:0], 1'b0};
          quot_next = {quot[10:0], 1'b1};
        end else begin
          rem_next  = {rem[11:0], 1'b0};
          quot_next = {quot[10:0], 1'b0};
        end
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd0) begin
          state_next = NORM;
        end
      end

      NORM: begin
        if (special) begin
          norm_res_next = special_res;
        end else if (exp_q >= 7'sd31) begin
          norm_res_next = {sign, 5'h1F, 10'h000};
        end else if (exp_q <= 7'sd0) begin
          norm_res_next = 16'h0000;
        end else begin
          norm_res_next = {sign, exp_q[4:0], mant_q};
        end
        state_next = DONE;
      end

      DONE: begin
        result_next = norm_res;
        done_next   = 1'b1;
        busy_next   = 1'b0;
        state_next  = IDLE;
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any operation and clears the datapath.
  always_ff @(posedge clk_59) begin
    if (reset_59) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= 16'h0000;
      rem         <= 13'h0000;
      quot        <= 12'h000;
      cnt         <= 4'd0;
      sign        <= 1'b0;
      exp_a       <= 5'h00;
      exp_b       <= 5'h00;
      man_b       <= 11'h000;
      special     <= 1'b0;
      special_res <= 16'h0000;
      norm_res    <= 16'h0000;
    end else begin
      state       <= state_next;
      busy        <= busy_next;
      done        <= done_next;
      result      <= result_next;
      rem         <= rem_next;
      quot        <= quot_next;
      cnt         <= cnt_next;
      sign        <= sign_next;
      exp_a       <= exp_a_next;
      exp_b       <= exp_b_next;
      man_b       <= man_b_next;
      special     <= special_next;
      special_res <= special_res_next;
      norm_res    <= norm_res_next;
    end
  end

endmodule

// File: doc/fp16_div_iter.md
# fp16_div_iter

Iterative IEEE-754 half-precision divider, the inverse companion to the pipelined multiplier in the FP datapath. It computes the quotient numA59 / numB59 with a start/done handshake. It produces one quotient bit per clock through restoring division. Rounding, subnormal and zero conventions match the multiplier: truncation, flush-to-zero, and a +0 result for zero. It serves as a low-area unit for the datapath, and its quotients can be multiplied back to cross-check the multiplier.

## Interface
- No parameters; format fixed at fp16 (1 sign, 5 exponent with bias 15, 10 mantissa bits).
- clk_59  input  1  single clock, rising-edge.
- reset_59  input  1  reset, synchronous and active-high.
- start_59  input  1  request; sampled only when busy_59=0.
- numA59  input  16  dividend; captured on the accepting edge.
- numB59  input  16  divisor; captured on the accepting edge.
- busy_59  output  1  high from the accepting edge until the edge that raises done_59.
- done_59  output  1  one-cycle pulse; Div_result_59 is valid from this cycle on.
- Div_result_59  output  16  quotient; holds its value until the next done_59.

## Operation
- States: IDLE, DIV, NORM, DONE.
- IDLE: if start_59=1, capture operands, set busy_59=1, load the remainder with mA and the counter with 11, then go to DIV. If start_59=0, stay in IDLE.
- DIV: runs 12 iterations. Each iteration computes trial = rem − mB. If trial ≥ 0, rem = trial<<1 and q bit = 1; otherwise rem = rem<<1 and q bit = 0. The result is q[11:0] = floor(mA·2^11 / mB).
  - mA and mB are 11-bit significands with the hidden 1.
  - rem is 13 bits wide.
- NORM: builds the result.
  - If q[11]=1: mant = q[10:1] and e = eA − eB + 15.
  - If q[11]=0: q[10] is guaranteed 1; mant = q[9:0] and e = eA − eB + 14.
  - e is computed as signed 7-bit.
  - Sign = sA ^ sB.
- Range rules, applied in NORM:
  - e ≥ 31 gives a signed infinity, {s,5'h1F,10'h0}.
  - e ≤ 0 gives 16'h0000.
  - Otherwise the result is {s, e[4:0], mant}.
- Special cases are decided at capture and override the NORM result; latency is unchanged. Priority, highest first:
  1. Either operand NaN (exponent 31 with mantissa ≠ 0), or inf/inf, or 0/0: result 16'h7E00.
  2. Dividend exponent 0 (zero or subnormal, flushed): result 16'h0000.
  3. Divisor exponent 0: result is signed infinity.
  4. Dividend infinite: result is signed infinity.
  5. Divisor infinite: result 16'h0000.
- Rounding is truncation toward zero. No exception flags are produced.
- DONE: done_59=1 and busy_59=0 for one cycle, then return to IDLE. start_59 is not accepted in the DONE cycle.

## Timing
- Reset values (synchronous): state IDLE, busy_59=0, done_59=0, Div_result_59=16'h0000. The datapath registers are cleared.
- Fixed latency: if start_59 is sampled at edge k, then Div_result_59 is updated and done_59 rises at edge k+14.
  - Edges k+1 to k+12 are DIV.
  - Edge k+13 is NORM.
  - done_59 is high for exactly one cycle.
- Throughput: one operation per 15 cycles. The earliest next accept is edge k+15.
- start_59 while busy_59=1 or during DONE: ignored, with no queuing, and the operands are not re-captured.
- Operand inputs may change freely after the accepting edge.
- reset_59 asserted mid-operation aborts at that edge. Outputs return to their reset values and no done_59 is produced.
- reset_59 and start_59 high on the same edge: reset wins and nothing is accepted.
- Div_result_59 changes only on the done edge or on reset.

## Test plan
- Basic quotients:
  - 0x4400 / 0x4000 → 0x4000, done_59 exactly 14 edges after start_59.
  - 0x3C00 / 0x4200 → 0x3555 (truncated 1/3).
  - 0xC400 / 0x4000 → 0xC000.
- Specials:
  - 0x0000 / 0xD750 → 0x0000.
  - 0xC000 / 0x0000 → 0xFC00.
  - 0x7E00 / 0x3C00 → 0x7E00.
  - 0x7C00 / 0x7C00 → 0x7E00.
  - 0x3C00 / 0x7C00 → 0x0000.
  - All with the same 14-edge latency.
- Range:
  - 0x7BFF / 0x0400 → 0x7C00 (overflow).
  - 0x0400 / 0x7BFF → 0x0000 (underflow).
- Handshake: hold start_59=1 continuously with changing operands. Accepts occur every 15 edges. Each result matches the operands present at its accepting edge, and operands applied during busy_59 are ignored.
- Reset mid-op: start at edge 0, reset_59 at edge 6. No done_59 follows, Div_result_59=0x0000, and the next start completes normally with the correct result.
- Round-trip: feed quotients into the multiplier with the divisor. The product is within 2 ulp of the dividend, for random normal operands whose quotients stay in range.
